kbd_buffer: RTL and testbench

KBD_BUFFER -- requirements
Module: kbd_buffer

---
 rtl/kbd_buffer.sv | 142 ++++++++++++++
 tb/tb_kbd_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_buffer.sv
// PS/2 scancode receive buffer: an 8-entry byte FIFO behind a two-register bus
// slave with a status/control register, a sticky overrun flag and a level interrupt.
module kbd_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  keyboard_data,
    input  logic        keyboard_rdy,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  fifo [8];
    logic [2:0]  wptr;
    logic [2:0]  rptr;
    logic [3:0]  count;
    logic        ien;
    logic        overrun;

    logic        req;
    logic        full;
    logic        empty;
    logic        rd_data;
    logic        rd_stat;
    logic        wr_stat;
    logic        pop;
    logic        push_ok;
    logic        push_drop;
    logic        unused_data_in;

    function automatic logic [31:0] status_word(input logic ovr, input logic ie, input logic rdy);
        return {29'b0, ovr, ie, rdy};
    endfunction

    assign unused_data_in = ^{data_in[31:3], data_in[0]};

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            IDLE: begin
                if (stb) begin
                    state_nxt = ACK;
                    req       = 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The whole transaction resolves on the IDLE->ACK edge, so the ACK cycle
    // already shows the popped FIFO and the updated control bits.
    assign full      = (count == 4'd8);
    assign empty     = (count == 4'd0);
    assign rd_data   = req && addr && !we;
    assign rd_stat   = req && !addr && !we;
    assign wr_stat   = req && !addr && we;
    assign pop       = rd_data && !empty;
    assign push_ok   = keyboard_rdy && (!full || pop);
    assign push_drop = keyboard_rdy && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= 3'd0;
            rptr  <= 3'd0;
            count <= 4'd0;
        end else begin
            if (push_ok)
                wptr <= wptr + 3'd1;
            if (pop)
                rptr <= rptr + 3'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            fifo[wptr] <= keyboard_data;
    end

    // A byte dropped in the same cycle as a clear request still leaves overrun set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ien     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr_stat)
                ien <= data_in[1];
            if (push_drop)
                overrun <= 1'b1;
            else if (wr_stat && data_in[2])
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 32'd0;
        end else if (pop) begin
            data_out <= {24'd0, fifo[rptr]};
        end else if (rd_stat) begin
            data_out <= status_word(overrun, ien, !empty);
        end else begin
            data_out <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= ien && !empty;
    end

endmodule

// File: tb/tb_kbd_buffer.sv
// Bench for kbd_buffer: directed scenarios plus random traffic, every cycle
// compared against a queue-based transaction model.
module tb_kbd_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  kd = 8'd0;
    logic        kr = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] din = 32'd0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    logic        m_ien = 1'b0;
    logic        m_ovr = 1'b0;
    logic        e_ack = 1'b0;
    logic [31:0] e_dout = 32'd0;
    logic        e_irq = 1'b0;

    kbd_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .keyboard_data (kd),
        .keyboard_rdy  (kr),
        .stb           (stb),
        .we            (we),
        .addr          (addr),
        .data_in       (din),
        .data_out      (data_out),
        .ack           (ack),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply the model's rules to the current inputs, cross the edge, compare.
    task automatic tick();
        logic        nx_ack;
        logic [31:0] nx_dout;
        logic        nx_irq;
        logic        popped;
        int          sz;
        nx_ack  = 1'b0;
        nx_dout = 32'd0;
        nx_irq  = 1'b0;
        if (rst) begin
            q.delete();
            m_ien = 1'b0;
            m_ovr = 1'b0;
        end else begin
            sz     = q.size();
            nx_irq = m_ien && (sz != 0);
            nx_ack = stb && !e_ack;
            popped = 1'b0;
            if (nx_ack) begin
                if (!we && addr && sz > 0) begin
                    nx_dout = {24'd0, q[0]};
                    popped  = 1'b1;
                end else if (!we && !addr) begin
                    nx_dout = {29'd0, m_ovr, m_ien, sz != 0};
                end else if (we && !addr) begin
                    m_ien = din[1];
                    if (din[2]) m_ovr = 1'b0;
                end
            end
            if (popped) void'(q.pop_front());
            if (kr) begin
                if (sz < 8 || popped) q.push_back(kd);
                else m_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        e_ack  = nx_ack;
        e_dout = nx_dout;
        e_irq  = nx_irq;
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("data_out", data_out, e_dout);
        chk("irq", {31'd0, irq}, {31'd0, e_irq});
    endtask

    task automatic bus(input logic w, input logic a, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
        stb  = 1'b1;
        we   = w;
        addr = a;
        din  = d;
        lat  = 0;
        r    = 32'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (ack === 1'b1) begin
                r = data_out;
                break;
            end
        end
        chk("bus_ack_seen", {31'd0, ack}, 32'd1);
        stb  = 1'b0;
        we   = 1'b0;
        addr = 1'b0;
        din  = 32'd0;
        tick();
    endtask

    task automatic rd(input logic a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        int          lat;
        bus(1'b0, a, 32'd0, r, lat);
        chk(tag, r, exp);
    endtask

    task automatic wr_stat(input logic [31:0] d);
        logic [31:0] r;
        int          lat;
        bus(1'b1, 1'b0, d, r, lat);
    endtask

    task automatic kb_push(input logic [7:0] b);
        kr = 1'b1;
        kd = b;
        tick();
        kr = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          lat;

        repeat (3) tick();
        kr = 1'b1;
        kd = 8'hAA;
        tick();
        kr  = 1'b0;
        rst = 1'b0;
        tick();
        rd(1'b0, 32'h0, "reset_status");

        // single byte round trip with latency
        kb_push(8'h1C);
        bus(1'b0, 1'b1, 32'd0, r, lat);
        chk("r030_data", r, 32'h0000001C);
        chk("r030_latency", lat, 32'd1);
        rd(1'b0, 32'h0, "r030_status");

        // overflow by one byte
        for (int i = 1; i <= 9; i++) kb_push(i[7:0]);
        rd(1'b0, 32'h5, "r031_status");
        for (int i = 1; i <= 8; i++) rd(1'b1, i, "r031_data");
        rd(1'b1, 32'h0, "r031_empty");
        wr_stat(32'h4);
        rd(1'b0, 32'h0, "r031_ovr_clear");

        // interrupt timing
        wr_stat(32'h2);
        kr = 1'b1;
        kd = 8'h5A;
        tick();
        kr = 1'b0;
        chk("r032_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("r032_irq_set", {31'd0, irq}, 32'd1);
        rd(1'b1, 32'h5A, "r032_data");
        chk("r032_irq_clear", {31'd0, irq}, 32'd0);

        // push coincident with a pop while full
        for (int i = 0; i < 8; i++) kb_push(8'h10 + i[7:0]);
        stb  = 1'b1;
        addr = 1'b1;
        we   = 1'b0;
        kr   = 1'b1;
        kd   = 8'hEE;
        tick();
        kr = 1'b0;
        chk("r033_ack", {31'd0, ack}, 32'd1);
        chk("r033_oldest", data_out, 32'h10);
        stb  = 1'b0;
        addr = 1'b0;
        tick();
        rd(1'b0, 32'h3, "r033_status");
        for (int i = 1; i < 8; i++) rd(1'b1, 32'h10 + i, "r033_data");
        rd(1'b1, 32'hEE, "r033_last");
        rd(1'b1, 32'h0, "r033_empty");

        // interleaved traffic across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            kb_push(8'h80 + i[7:0]);
            if (i >= 2) rd(1'b1, 32'h80 + i - 2, "r034_order");
        end
        rd(1'b1, 32'h92, "r034_tail0");
        rd(1'b1, 32'h93, "r034_tail1");
        for (int i = 0; i < 9; i++) kb_push(8'hC0 + i[7:0]);
        rd(1'b0, 32'h7, "r034_ovr_set");
        wr_stat(32'h4);
        rd(1'b0, 32'h1, "r034_ovr_clear");
        for (int i = 0; i < 8; i++) rd(1'b1, 32'hC0 + i, "r034_drain");

        // reset in the middle of a transaction
        wr_stat(32'h2);
        for (int i = 0; i < 3; i++) kb_push(8'h30 + i[7:0]);
        tick();
        chk("r035_irq_before", {31'd0, irq}, 32'd1);
        stb = 1'b1;
        tick();
        chk("r035_in_ack", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        stb = 1'b0;
        tick();
        chk("r035_ack_abort", {31'd0, ack}, 32'd0);
        chk("r035_irq_reset", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        tick();
        rd(1'b0, 32'h0, "r035_status");
        rd(1'b1, 32'h0, "r035_empty");

        // random traffic: light then heavy keyboard load
        for (int c = 0; c < 4000; c++) begin
            if (c < 2000) kr = ($urandom_range(0, 5) == 0);
            else          kr = ($urandom_range(0, 1) == 0);
            kd = 8'($urandom);
            if (!stb && $urandom_range(0, 2) == 0) begin
                stb  = 1'b1;
                we   = 1'($urandom);
                addr = 1'($urandom);
                din  = $urandom;
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
            if (ack === 1'b1) begin
                stb = 1'b0;
                we  = 1'b0;
            end
        end
        kr  = 1'b0;
        stb = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
